// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Never below one bit, so a single-digit build still has a legal counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fa_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice.
module fa_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c,
    output logic [DIGIT-1:0] o_s,
    output logic             o_c
);

    logic [DIGIT:0] cy;

    assign cy[0] = i_c;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign o_s[i]  = i_a[i] ^ i_b[i] ^ cy[i];
        assign cy[i+1] = (i_a[i] & i_b[i]) | (cy[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_c = cy[DIGIT];

endmodule

// File: rtl/adder_serial.sv
// Digit-serial WIDTH-bit adder behind valid/ready handshakes.
// Define ADDER_SERIAL_SUB_EN to add the i_sub subtract-select port.
module adder_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
`ifdef ADDER_SERIAL_SUB_EN
    input  logic             i_sub,
`endif
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state;
    state_t           state_nx;
    logic             rst_done;
    logic             sub_sel;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_s;
    logic             dig_c;

`ifdef ADDER_SERIAL_SUB_EN
    assign sub_sel = i_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign accept = i_valid && o_ready;
    assign last   = (cnt == LAST);
    assign dig_a  = a_q[int'(cnt)*DIGIT +: DIGIT];
    assign dig_b  = b_q[int'(cnt)*DIGIT +: DIGIT];

    fa_digit #(
        .DIGIT(DIGIT)
    ) u_fa (
        .i_a(dig_a),
        .i_b(dig_b),
        .i_c(carry_q),
        .o_s(dig_s),
        .o_c(dig_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE) && rst_done;
        o_valid = (state == DONE);
    end

    // Holds o_ready low for the cycle right after a reset edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Subtract folds into the adder by inverting B and the carry-in once at accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            o_s     <= '0;
            o_c     <= 1'b0;
        end else if (accept) begin
            a_q     <= i_a;
            b_q     <= i_b ^ {WIDTH{sub_sel}};
            carry_q <= i_c ^ sub_sel;
            cnt     <= '0;
            o_s     <= '0;
            o_c     <= 1'b0;
        end else if (state == RUN) begin
            o_s[int'(cnt)*DIGIT +: DIGIT] <= dig_s;
            carry_q <= dig_c;
            if (last) begin
                o_c <= dig_c;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_serial.sv
// Scoreboard bench driving three adder_serial builds: 16/4, 8/8 and 32/1.
module tb_adder_serial;

    typedef struct {
        logic [31:0] s;
        logic        c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vin[3];
    logic        rin[3];
    logic        cin[3];
    logic        sin[3];
    logic [31:0] ain[3];
    logic [31:0] bin[3];
    logic        ordy[3];
    logic        ovld[3];
    logic        oc[3];
    logic [15:0] s0;
    logic [7:0]  s1;
    logic [31:0] s2;

    int wd[3] = '{16, 8, 32};
    int nd[3] = '{4, 1, 32};

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    adder_serial #(.WIDTH(16), .DIGIT(4)) u_d0 (
        .i_clk(clk), .i_rst(rst),
`ifdef ADDER_SERIAL_SUB_EN
        .i_sub(sin[0]),
`endif
        .i_valid(vin[0]), .o_ready(ordy[0]),
        .i_a(ain[0][15:0]), .i_b(bin[0][15:0]), .i_c(cin[0]),
        .o_valid(ovld[0]), .i_ready(rin[0]),
        .o_s(s0), .o_c(oc[0])
    );

    adder_serial #(.WIDTH(8), .DIGIT(8)) u_d1 (
        .i_clk(clk), .i_rst(rst),
`ifdef ADDER_SERIAL_SUB_EN
        .i_sub(sin[1]),
`endif
        .i_valid(vin[1]), .o_ready(ordy[1]),
        .i_a(ain[1][7:0]), .i_b(bin[1][7:0]), .i_c(cin[1]),
        .o_valid(ovld[1]), .i_ready(rin[1]),
        .o_s(s1), .o_c(oc[1])
    );

    adder_serial #(.WIDTH(32), .DIGIT(1)) u_d2 (
        .i_clk(clk), .i_rst(rst),
`ifdef ADDER_SERIAL_SUB_EN
        .i_sub(sin[2]),
`endif
        .i_valid(vin[2]), .o_ready(ordy[2]),
        .i_a(ain[2]), .i_b(bin[2]), .i_c(cin[2]),
        .o_valid(ovld[2]), .i_ready(rin[2]),
        .o_s(s2), .o_c(oc[2])
    );

    function automatic logic [31:0] get_s(input int d);
        case (d)
            0:       return {16'h0, s0};
            1:       return {24'h0, s1};
            default: return s2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int d, input logic [31:0] av,
                         input logic [31:0] bv, input logic cv,
                         input logic sv, input int stall,
                         input string tag);
        exp_t        e;
        logic [32:0] full;
        logic [31:0] m;
        logic [31:0] be;
        logic        ce;
        int          w;
        int          n;
        w    = wd[d];
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        be   = sv ? ~bv : bv;
        ce   = sv ? ~cv : cv;
        full = {1'b0, av & m} + {1'b0, be & m} + {32'h0, ce};
        e.s  = full[31:0] & m;
        e.c  = full[w];
        sb.push_back(e);
        n = 0;
        while (!ordy[d] && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, ordy[d], 1);
        vin[d] = 1'b1;
        ain[d] = av;
        bin[d] = bv;
        cin[d] = cv;
        sin[d] = sv;
        tick();
        vin[d] = 1'b0;
        ain[d] = $urandom;
        bin[d] = $urandom;
        cin[d] = 1'($urandom_range(0, 1));
        sin[d] = 1'($urandom_range(0, 1));
        chk({tag, "_busy"}, ordy[d], 0);
        n = 0;
        while (!ovld[d] && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, nd[d]);
        e = sb.pop_front();
        chk({tag, "_s"}, get_s(d), e.s);
        chk({tag, "_c"}, oc[d], e.c);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_hold_v"}, ovld[d], 1);
            chk({tag, "_hold_s"}, get_s(d), e.s);
            chk({tag, "_hold_c"}, oc[d], e.c);
            chk({tag, "_hold_r"}, ordy[d], 0);
        end
        rin[d] = 1'b1;
        tick();
        rin[d] = 1'b0;
        chk({tag, "_hs_v"}, ovld[d], 0);
        chk({tag, "_hs_r"}, ordy[d], 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0;
            rin[i] = 1'b0;
            cin[i] = 1'b0;
            sin[i] = 1'b0;
            ain[i] = '0;
            bin[i] = '0;
        end
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_rdy", ordy[i], 0);
            chk("rst_vld", ovld[i], 0);
            chk("rst_s", get_s(i), 0);
            chk("rst_c", oc[i], 0);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("idle_rdy", ordy[i], 1);
            chk("idle_vld", ovld[i], 0);
        end

        do_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 0, "ripple");
        do_op(0, 32'h1234, 32'h4321, 1'b1, 1'b0, 5, "bp");

        vin[0] = 1'b1;
        ain[0] = 32'hAAAA;
        bin[0] = 32'h5555;
        cin[0] = 1'b0;
        sin[0] = 1'b0;
        tick();
        vin[0] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_vld", ovld[0], 0);
        chk("mid_rst_rdy", ordy[0], 0);
        chk("mid_rst_s", get_s(0), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_rst_novld", ovld[0], 0);
        end
        do_op(0, 32'h0003, 32'h0004, 1'b0, 1'b0, 0, "post_rst");

`ifdef ADDER_SERIAL_SUB_EN
        do_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, 0, "sub_neg");
        do_op(0, 32'h0007, 32'h0005, 1'b1, 1'b1, 1, "sub_pos");
`endif

        for (int d = 0; d < 3; d++) begin
            int cnt;
            cnt = (d == 0) ? 50 : 1000;
            for (int k = 0; k < cnt; k++) begin
                logic sv;
`ifdef ADDER_SERIAL_SUB_EN
                sv = 1'($urandom_range(0, 1));
`else
                sv = 1'b0;
`endif
                do_op(d, $urandom, $urandom, 1'($urandom_range(0, 1)),
                      sv, int'($urandom_range(0, 2)), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
